// File: rtl/pe_inst_pkg.sv
// Shared definitions for the PE instruction sequencer: sizes, field layout,
// selector limits, NOP word and sequencer state encoding.
package pe_inst_pkg;

  localparam int unsigned INST_W = 48;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned LEN_W  = ADDR_W + 1;

  // Instruction word layout: {fu_opcode, switch_9x7, switch_5x4, reg_file_sel}
  localparam int unsigned FU_LSB   = 44;
  localparam int unsigned FU_W     = 4;
  localparam int unsigned SW97_LSB = 16;
  localparam int unsigned SW97_W   = 28;
  localparam int unsigned SW54_LSB = 4;
  localparam int unsigned SW54_W   = 12;
  localparam int unsigned RF_LSB   = 0;
  localparam int unsigned RF_W     = 4;

  // switch_9x7 holds LSU, opA, opB, N, S, W, E selectors (MSB first)
  localparam int unsigned SEL97_W   = 4;
  localparam int unsigned SEL97_N   = 7;
  localparam int unsigned SEL97_MAX = 8;
  localparam int unsigned SEL54_W   = 3;
  localparam int unsigned SEL54_N   = 4;
  localparam int unsigned SEL54_MAX = 4;

  localparam logic [INST_W-1:0] NOP_INST = '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

endpackage

// File: rtl/pe_inst_sequencer_if.sv
// PE instruction interface: the sequencer drives inst/inst_valid/pc, the PE side drives stall.
interface pe_inst_sequencer_if;
  import pe_inst_pkg::*;

  logic [INST_W-1:0] inst;
  logic              inst_valid;
  logic [ADDR_W-1:0] pc;
  logic              stall;

  modport master (output inst, inst_valid, pc, input stall);
  modport slave  (input inst, inst_valid, pc, output stall);

endinterface

// File: rtl/pe_inst_field_check.sv
// Combinational selector range check on the switch fields of one instruction word.
module pe_inst_field_check
  import pe_inst_pkg::*;
(
  input  logic [SW97_W-1:0] sw97,
  input  logic [SW54_W-1:0] sw54,
  output logic              err_c
);

  always_comb begin
    err_c = 1'b0;
    for (int i = 0; i < SEL97_N; i++) begin
      if (sw97[i*SEL97_W +: SEL97_W] > SEL97_W'(SEL97_MAX)) err_c = 1'b1;
    end
    for (int j = 0; j < SEL54_N; j++) begin
      if (sw54[j*SEL54_W +: SEL54_W] > SEL54_W'(SEL54_MAX)) err_c = 1'b1;
    end
  end

endmodule

// File: rtl/pe_inst_sequencer.sv
// Plays back a loaded instruction context to one PE for loop_cnt iterations.
// Optional selector range checking is enabled with PE_SEQ_FIELD_CHECK_EN.
module pe_inst_sequencer
  import pe_inst_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_we,
  input  logic [ADDR_W-1:0]   cfg_addr,
  input  logic [INST_W-1:0]   cfg_wdata,
  input  logic                start,
  input  logic [LEN_W-1:0]    prog_len,
  input  logic [CNT_W-1:0]    loop_cnt,
  pe_inst_sequencer_if.master bus,
  output logic                busy,
  output logic                done,
  output logic                err_sel
);

  seq_state_e        state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [LEN_W-1:0]  len_q;
  logic [CNT_W-1:0]  loops_q;
  logic [CNT_W-1:0]  iter_q;
  logic [INST_W-1:0] inst_q;
  logic              valid_q;
  logic              busy_q;
  logic              done_q;

  logic [INST_W-1:0] mem [DEPTH];

  logic [LEN_W-1:0]  len_sat_c;
  logic [INST_W-1:0] first_word_c;
  logic [INST_W-1:0] next_word_c;
  logic [ADDR_W-1:0] next_pc_c;
  logic              last_entry_c;
  logic              last_iter_c;

  // Entry 0 is forwarded from a same-cycle config write so write-then-start sees new data
  always_comb begin
    len_sat_c    = (prog_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : prog_len;
    first_word_c = (cfg_we && (cfg_addr == '0)) ? cfg_wdata : mem[0];
    last_entry_c = ({1'b0, pc_q} == (len_q - LEN_W'(1)));
    last_iter_c  = (iter_q == (loops_q - CNT_W'(1)));
    next_pc_c    = last_entry_c ? '0 : pc_q + ADDR_W'(1);
    next_word_c  = mem[next_pc_c];
  end

  // Context memory is not reset; only writable while idle
  always_ff @(posedge clk) begin
    if (cfg_we && (state_q == ST_IDLE)) mem[cfg_addr] <= cfg_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      len_q   <= '0;
      loops_q <= '0;
      iter_q  <= '0;
      inst_q  <= NOP_INST;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            if (len_sat_c != '0) begin
              state_q <= ST_RUN;
              len_q   <= len_sat_c;
              loops_q <= (loop_cnt == '0) ? CNT_W'(1) : loop_cnt;
              iter_q  <= '0;
              pc_q    <= '0;
              inst_q  <= first_word_c;
              valid_q <= 1'b1;
              busy_q  <= 1'b1;
            end else begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (!bus.stall) begin
            if (last_entry_c && last_iter_c) begin
              state_q <= ST_DONE;
              pc_q    <= '0;
              iter_q  <= '0;
              inst_q  <= NOP_INST;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              pc_q   <= next_pc_c;
              inst_q <= next_word_c;
              if (last_entry_c) iter_q <= iter_q + CNT_W'(1);
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.inst       = inst_q;
  assign bus.inst_valid = valid_q;
  assign bus.pc         = pc_q;
  assign busy           = busy_q;
  assign done           = done_q;

`ifdef PE_SEQ_FIELD_CHECK_EN
  logic [INST_W-1:0] check_word_c;
  logic              field_err_c;
  logic              err_q;

  // Check the word about to be loaded so the flag lines up with it on inst
  assign check_word_c = (state_q == ST_IDLE) ? first_word_c : next_word_c;

  pe_inst_field_check u_field_check (
    .sw97  (check_word_c[SW97_LSB +: SW97_W]),
    .sw54  (check_word_c[SW54_LSB +: SW54_W]),
    .err_c (field_err_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if ((state_q == ST_IDLE) && start) begin
      err_q <= (len_sat_c != '0) && field_err_c;
    end else if ((state_q == ST_RUN) && !bus.stall && !(last_entry_c && last_iter_c)) begin
      err_q <= err_q | field_err_c;
    end
  end

  assign err_sel = err_q;
`else
  assign err_sel = 1'b0;
`endif

endmodule

// File: tb/tb_pe_inst_sequencer.sv
// Scoreboard bench for pe_inst_sequencer: directed programs push expected issue
// words and done pulses; a negedge monitor pops and compares.
module tb_pe_inst_sequencer;
  import pe_inst_pkg::*;

  typedef struct {
    bit                is_done;
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] pc;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_we;
  logic [ADDR_W-1:0] cfg_addr;
  logic [INST_W-1:0] cfg_wdata;
  logic              start;
  logic [LEN_W-1:0]  prog_len;
  logic [CNT_W-1:0]  loop_cnt;
  logic              busy;
  logic              done;
  logic              err_sel;

  pe_inst_sequencer_if bus ();

  pe_inst_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .start     (start),
    .prog_len  (prog_len),
    .loop_cnt  (loop_cnt),
    .bus       (bus.master),
    .busy      (busy),
    .done      (done),
    .err_sel   (err_sel)
  );

  always #5 clk = ~clk;

  int   n_pass = 0;
  int   n_total = 0;
  int   valid_cycles = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [INST_W-1:0] w, input logic [ADDR_W-1:0] p);
    exp_t e;
    e.is_done = 1'b0;
    e.inst    = w;
    e.pc      = p;
    exp_q.push_back(e);
  endtask

  task automatic push_done();
    exp_t e;
    e.is_done = 1'b1;
    e.inst    = NOP_INST;
    e.pc      = '0;
    exp_q.push_back(e);
  endtask

  task automatic push_prog(input int len, input int loops, input logic [INST_W-1:0] base);
    for (int l = 0; l < loops; l++)
      for (int i = 0; i < len; i++) push_word(base + INST_W'(i), ADDR_W'(i));
    push_done();
  endtask

  task automatic load(input int addr, input logic [INST_W-1:0] data);
    cfg_we    = 1'b1;
    cfg_addr  = ADDR_W'(addr);
    cfg_wdata = data;
    tick();
    cfg_we    = 1'b0;
  endtask

  task automatic run(input int len, input int loops);
    prog_len = LEN_W'(len);
    loop_cnt = CNT_W'(loops);
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    if (!seen) begin
      n_total++;
      $display("FAIL %s_timeout: done not seen within 300 cycles", name);
    end
    tick();
    chk({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic wait_pc(input logic [ADDR_W-1:0] p);
    bit seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (bus.inst_valid && bus.pc == p) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    if (!seen) begin
      n_total++;
      $display("FAIL wait_pc_timeout: pc %0d not reached", p);
    end
  endtask

  // Monitor: a word is consumed on a valid, non-stalled cycle; held words are compared in place
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.inst_valid) begin
        valid_cycles++;
        if (exp_q.size() == 0 || exp_q[0].is_done) begin
          n_total++;
          $display("FAIL unexpected_issue: got inst %0h pc %0d expected none", bus.inst, bus.pc);
        end else if (bus.stall) begin
          chk("held_inst", 64'(bus.inst), 64'(exp_q[0].inst));
        end else begin
          mon_e = exp_q.pop_front();
          chk("issue_inst", 64'(bus.inst), 64'(mon_e.inst));
          chk("issue_pc", 64'(bus.pc), 64'(mon_e.pc));
        end
      end
      if (done) begin
        n_total++;
        if (exp_q.size() != 0 && exp_q[0].is_done) begin
          void'(exp_q.pop_front());
          n_pass++;
        end else begin
          $display("FAIL unexpected_done: got done=1 expected pending items=%0d", exp_q.size());
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  localparam logic [INST_W-1:0] W_T1 = 48'h0000_0700_002F;

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    start = 1'b0; prog_len = '0; loop_cnt = '0; bus.stall = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_inst", 64'(bus.inst), 64'(NOP_INST));
    chk("rst_valid", 64'(bus.inst_valid), 64'd0);
    chk("rst_pc", 64'(bus.pc), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err_sel), 64'd0);

    // Single entry, single iteration: latency 1 issue, then done
    load(0, W_T1);
    push_word(W_T1, '0); push_done();
    run(1, 1);
    chk("t1_inst", 64'(bus.inst), 64'(W_T1));
    chk("t1_valid", 64'(bus.inst_valid), 64'd1);
    chk("t1_busy", 64'(busy), 64'd1);
    tick();
    chk("t1_done", 64'(done), 64'd1);
    chk("t1_nop", 64'(bus.inst), 64'(NOP_INST));
    chk("t1_valid_low", 64'(bus.inst_valid), 64'd0);
    chk("t1_busy_low", 64'(busy), 64'd0);
    tick();
    chk("t1_done_pulse", 64'(done), 64'd0);
    chk("t1_drained", 64'(exp_q.size()), 64'd0);

    // Four entries, three iterations
    for (int i = 0; i < 4; i++) load(i, INST_W'(i + 1));
    push_prog(4, 3, 48'h1);
    valid_cycles = 0;
    run(4, 3);
    wait_done("t2");
    chk("t2_cycles", 64'(valid_cycles), 64'd12);

    // Same program, stall two cycles while pc=2
    push_prog(4, 3, 48'h1);
    valid_cycles = 0;
    run(4, 3);
    wait_pc(2);
    bus.stall = 1'b1;
    tick(); tick();
    chk("t3_hold_pc", 64'(bus.pc), 64'd2);
    chk("t3_hold_inst", 64'(bus.inst), 64'h3);
    bus.stall = 1'b0;
    wait_done("t3");
    chk("t3_cycles", 64'(valid_cycles), 64'd14);

    // Zero-length program goes straight to done
    push_done();
    valid_cycles = 0;
    run(0, 5);
    chk("t4_done", 64'(done), 64'd1);
    chk("t4_valid", 64'(bus.inst_valid), 64'd0);
    wait_done("t4");
    chk("t4_cycles", 64'(valid_cycles), 64'd0);

    // Oversized prog_len saturates to full depth
    for (int i = 4; i < 16; i++) load(i, INST_W'(i + 1));
    push_prog(16, 1, 48'h1);
    valid_cycles = 0;
    run(20, 1);
    wait_done("t5");
    chk("t5_cycles", 64'(valid_cycles), 64'd16);

    // loop_cnt of zero runs once
    push_prog(4, 1, 48'h1);
    valid_cycles = 0;
    run(4, 0);
    wait_done("t6");
    chk("t6_cycles", 64'(valid_cycles), 64'd4);

    // Reset mid-run aborts without done; memory survives
    push_word(48'h1, 4'd0); push_word(48'h2, 4'd1);
    run(4, 3);
    wait_pc(2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t7_inst", 64'(bus.inst), 64'(NOP_INST));
    chk("t7_busy", 64'(busy), 64'd0);
    chk("t7_done", 64'(done), 64'd0);
    chk("t7_valid", 64'(bus.inst_valid), 64'd0);
    tick();
    chk("t7_no_done", 64'(done), 64'd0);
    chk("t7_drained", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    push_prog(4, 1, 48'h1);
    run(4, 1);
    wait_done("t7_replay");

    // Config write during RUN is ignored
    push_prog(4, 1, 48'h1);
    run(4, 1);
    cfg_we = 1'b1; cfg_addr = 4'd1; cfg_wdata = 48'hAA;
    tick();
    cfg_we = 1'b0;
    wait_done("t8");
    push_prog(4, 1, 48'h1);
    run(4, 1);
    wait_done("t8_recheck");

    // Write and start in the same cycle: entry 0 reflects the write
    push_word(48'h55, '0); push_done();
    cfg_we = 1'b1; cfg_addr = '0; cfg_wdata = 48'h55;
    run(1, 1);
    cfg_we = 1'b0;
    chk("t9_inst", 64'(bus.inst), 64'h55);
    wait_done("t9");

`ifdef PE_SEQ_FIELD_CHECK_EN
    // opA selector of 9 flags err_sel with the word; sticky until next start
    load(0, 48'h0090_0000_0000);
    load(1, 48'h1);
    push_word(48'h0090_0000_0000, 4'd0); push_word(48'h1, 4'd1); push_done();
    run(2, 1);
    chk("t10_err_rise", 64'(err_sel), 64'd1);
    tick();
    chk("t10_err_sticky", 64'(err_sel), 64'd1);
    wait_done("t10");
    chk("t10_err_idle", 64'(err_sel), 64'd1);
    push_word(48'h1, 4'd0); push_done();
    load(0, 48'h1);
    run(1, 1);
    chk("t10_err_clear", 64'(err_sel), 64'd0);
    wait_done("t10_clean");
`else
    chk("t10_err_tied", 64'(err_sel), 64'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
